ads1278_frame_avg: RTL and testbench

- Sits directly downstream of the ADS1278 acquisition driver's 192-bit frame FIFO, in the user clock domain.
- Accepts 8-channel 24-bit signed frames over a valid/ready handshake and averages 2^P_AVG_LOG2 consecutive frames per channel.
- Emits the averaged results as a serial stream of tagged 24-bit channel words over a second valid/ready handshake, for the packetiser/UART stage.

---
 rtl/ads1278_frame_avg.sv | 195 +++++++++++++++++++
 tb/tb_ads1278_frame_avg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ads1278_frame_avg.sv
// Averages 2^P_AVG_LOG2 ADS1278 frames per channel and streams tagged 24-bit channel words.
// Define ADS1278_FRAME_HEADER_EN to prefix every block with a header word (id 4'hF).
module ads1278_frame_avg #(
    parameter int unsigned P_AVG_LOG2 = 4,
    parameter logic [7:0]  P_CH_MASK  = 8'hFF
) (
    input  logic         i_sysclk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic [191:0] i_frame_data,
    input  logic         i_frame_valid,
    output logic         o_frame_ready,
    output logic [23:0]  o_ch_data,
    output logic [3:0]   o_ch_id,
    output logic         o_ch_valid,
    output logic         o_ch_last,
    input  logic         i_ch_ready,
    output logic [15:0]  o_block_cnt
);

    localparam int unsigned AccW = 24 + P_AVG_LOG2;
    localparam int unsigned CntW = P_AVG_LOG2 + 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << P_AVG_LOG2) - 1);

    function automatic logic [2:0] first_en(input logic [7:0] m);
        first_en = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) first_en = 3'(i);
    endfunction

    function automatic logic [2:0] last_en(input logic [7:0] m);
        last_en = 3'd0;
        for (int i = 0; i < 8; i++) if (m[i]) last_en = 3'(i);
    endfunction

    // Lowest enabled id strictly above cur; masked ids cost no cycles.
    function automatic logic [2:0] next_en(input logic [2:0] cur);
        next_en = cur;
        for (int i = 7; i >= 0; i--) if (P_CH_MASK[i] && (3'(i) > cur)) next_en = 3'(i);
    endfunction

    localparam logic [2:0] FirstId = first_en(P_CH_MASK);
    localparam logic [2:0] LastId  = last_en(P_CH_MASK);

`ifdef ADS1278_FRAME_HEADER_EN
    typedef enum logic [1:0] {StAcc = 2'd0, StEmit = 2'd1, StHdr = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StAcc = 2'd0, StEmit = 2'd1} state_e;
`endif

    state_e                 state_q, state_d;
    logic                   frame_ready_q, frame_ready_d;
    logic signed [AccW-1:0] acc_q [8];
    logic signed [AccW-1:0] acc_d [8];
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [23:0]            obuf_q [8];
    logic [23:0]            obuf_d [8];
    logic [23:0]            ch_data_q, ch_data_d;
    logic [3:0]             ch_id_q, ch_id_d;
    logic                   ch_valid_q, ch_valid_d;
    logic                   ch_last_q, ch_last_d;
    logic [15:0]            block_cnt_q, block_cnt_d;

    logic signed [AccW-1:0] sum [8];
    logic [23:0]            res [8];
    logic                   accept;
    logic                   ch_fire;
    logic [2:0]             nid;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sum[i] = acc_q[i] + AccW'(signed'(i_frame_data[24*i +: 24]));
            res[i] = 24'(sum[i] >>> P_AVG_LOG2);
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        obuf_d      = obuf_q;
        ch_data_d   = ch_data_q;
        ch_id_d     = ch_id_q;
        ch_valid_d  = ch_valid_q;
        ch_last_d   = ch_last_q;
        block_cnt_d = block_cnt_q;
        accept      = frame_ready_q && i_frame_valid;
        ch_fire     = ch_valid_q && i_ch_ready;
        nid         = next_en(ch_id_q[2:0]);

        if (i_clr) begin
            acc_d      = '{default: '0};
            cnt_d      = '0;
            ch_valid_d = 1'b0;
            ch_last_d  = 1'b0;
            state_d    = StAcc;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        if (cnt_q == CntLast) begin
                            acc_d       = '{default: '0};
                            cnt_d       = '0;
                            obuf_d      = res;
                            block_cnt_d = block_cnt_q + 16'd1;
`ifdef ADS1278_FRAME_HEADER_EN
                            state_d    = StHdr;
                            ch_valid_d = 1'b1;
                            ch_id_d    = 4'hF;
                            ch_data_d  = {8'hA5, block_cnt_q + 16'd1};
                            ch_last_d  = (P_CH_MASK == 8'h00);
`else
                            if (P_CH_MASK != 8'h00) begin
                                state_d    = StEmit;
                                ch_valid_d = 1'b1;
                                ch_id_d    = {1'b0, FirstId};
                                ch_data_d  = res[FirstId];
                                ch_last_d  = (FirstId == LastId);
                            end
`endif
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
`ifdef ADS1278_FRAME_HEADER_EN
                StHdr: begin
                    if (ch_fire) begin
                        if (P_CH_MASK == 8'h00) begin
                            state_d    = StAcc;
                            ch_valid_d = 1'b0;
                            ch_last_d  = 1'b0;
                        end else begin
                            state_d   = StEmit;
                            ch_id_d   = {1'b0, FirstId};
                            ch_data_d = obuf_q[FirstId];
                            ch_last_d = (FirstId == LastId);
                        end
                    end
                end
`endif
                StEmit: begin
                    if (ch_fire) begin
                        if (ch_last_q) begin
                            state_d    = StAcc;
                            ch_valid_d = 1'b0;
                            ch_last_d  = 1'b0;
                        end else begin
                            ch_id_d   = {1'b0, nid};
                            ch_data_d = obuf_q[nid];
                            ch_last_d = (nid == LastId);
                        end
                    end
                end
                default: state_d = StAcc;
            endcase
        end

        frame_ready_d = (state_d == StAcc);
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StAcc;
            frame_ready_q <= 1'b0;
            acc_q         <= '{default: '0};
            cnt_q         <= '0;
            obuf_q        <= '{default: '0};
            ch_data_q     <= '0;
            ch_id_q       <= '0;
            ch_valid_q    <= 1'b0;
            ch_last_q     <= 1'b0;
            block_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            frame_ready_q <= frame_ready_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            obuf_q        <= obuf_d;
            ch_data_q     <= ch_data_d;
            ch_id_q       <= ch_id_d;
            ch_valid_q    <= ch_valid_d;
            ch_last_q     <= ch_last_d;
            block_cnt_q   <= block_cnt_d;
        end
    end

    assign o_frame_ready = frame_ready_q;
    assign o_ch_data     = ch_data_q;
    assign o_ch_id       = ch_id_q;
    assign o_ch_valid    = ch_valid_q;
    assign o_ch_last     = ch_last_q;
    assign o_block_cnt   = block_cnt_q;

endmodule

// File: tb/tb_ads1278_frame_avg.sv
// Directed bench for ads1278_frame_avg: three instances (average, mask, extremes).
`timescale 1ns/1ps
module tb_ads1278_frame_avg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         clr    [3];
    logic [191:0] fdata  [3];
    logic         fvalid [3];
    logic         fready [3];
    logic [23:0]  cdata  [3];
    logic [3:0]   cid    [3];
    logic         cvalid [3];
    logic         clast  [3];
    logic         cready [3];
    logic [15:0]  bcnt   [3];

    logic [7:0]   dut_mask [3];
    logic [23:0]  exp_w    [8];
    logic [15:0]  exp_cnt;
    int           n_cmp = 0;
    int           n_err = 0;

    ads1278_frame_avg #(.P_AVG_LOG2(2), .P_CH_MASK(8'hFF)) u_avg (
        .i_sysclk(clk), .i_rst_n(rst_n), .i_clr(clr[0]), .i_frame_data(fdata[0]),
        .i_frame_valid(fvalid[0]), .o_frame_ready(fready[0]), .o_ch_data(cdata[0]),
        .o_ch_id(cid[0]), .o_ch_valid(cvalid[0]), .o_ch_last(clast[0]),
        .i_ch_ready(cready[0]), .o_block_cnt(bcnt[0])
    );

    ads1278_frame_avg #(.P_AVG_LOG2(2), .P_CH_MASK(8'b1000_0001)) u_mask (
        .i_sysclk(clk), .i_rst_n(rst_n), .i_clr(clr[1]), .i_frame_data(fdata[1]),
        .i_frame_valid(fvalid[1]), .o_frame_ready(fready[1]), .o_ch_data(cdata[1]),
        .o_ch_id(cid[1]), .o_ch_valid(cvalid[1]), .o_ch_last(clast[1]),
        .i_ch_ready(cready[1]), .o_block_cnt(bcnt[1])
    );

    ads1278_frame_avg #(.P_AVG_LOG2(8), .P_CH_MASK(8'hFF)) u_ext (
        .i_sysclk(clk), .i_rst_n(rst_n), .i_clr(clr[2]), .i_frame_data(fdata[2]),
        .i_frame_valid(fvalid[2]), .o_frame_ready(fready[2]), .o_ch_data(cdata[2]),
        .o_ch_id(cid[2]), .o_ch_valid(cvalid[2]), .o_ch_last(clast[2]),
        .i_ch_ready(cready[2]), .o_block_cnt(bcnt[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int k, input logic [191:0] data);
        fdata[k]  = data;
        fvalid[k] = 1'b1;
        for (int n = 0; n < 64 && !fready[k]; n++) tick();
        check("frame_ready", 32'(fready[k]), 1);
        tick();
        fvalid[k] = 1'b0;
    endtask

    task automatic recv_word(input int k, input logic [3:0] id, input logic [23:0] data,
                             input logic last, input string tag);
        cready[k] = 1'b1;
        for (int n = 0; n < 64 && !cvalid[k]; n++) tick();
        check({tag, " valid"}, 32'(cvalid[k]), 1);
        check({tag, " id"}, 32'(cid[k]), 32'(id));
        check({tag, " data"}, 32'(cdata[k]), 32'(data));
        check({tag, " last"}, 32'(clast[k]), 32'(last));
        tick();
    endtask

    task automatic recv_block(input int k, input int last_id, input string tag);
`ifdef ADS1278_FRAME_HEADER_EN
        recv_word(k, 4'hF, {8'hA5, exp_cnt}, dut_mask[k] == 8'h00, {tag, " hdr"});
`endif
        for (int i = 0; i < 8; i++)
            if (dut_mask[k][i]) recv_word(k, 4'(i), exp_w[i], i == last_id, tag);
        check({tag, " valid_after_last"}, 32'(cvalid[k]), 0);
        check({tag, " ready_after_last"}, 32'(fready[k]), 1);
        check({tag, " block_cnt"}, 32'(bcnt[k]), 32'(exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [191:0] f;
        dut_mask = '{8'hFF, 8'h81, 8'hFF};
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0; fdata[k] = '0; fvalid[k] = 1'b0; cready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst frame_ready", 32'(fready[k]), 0);
            check("rst ch_valid", 32'(cvalid[k]), 0);
            check("rst ch_last", 32'(clast[k]), 0);
            check("rst ch_data", 32'(cdata[k]), 0);
            check("rst ch_id", 32'(cid[k]), 0);
            check("rst block_cnt", 32'(bcnt[k]), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) check("ready_after_reset", 32'(fready[k]), 1);

        // Averaging with floor rounding on negative sums.
        for (int j = 0; j < 4; j++) begin
            f = '0;
            f[23:0]  = 24'(100 + j);
            f[47:24] = (j == 0) ? 24'hFFFFFD : 24'hFFFFFE;
            for (int i = 2; i < 7; i++) f[24*i +: 24] = 24'(i) << 16;
            f[191:168] = (j % 2 == 0) ? 24'hFFFFFB : 24'hFFFFFA;
            send_frame(0, f);
        end
        check("latency ch_valid", 32'(cvalid[0]), 1);
        check("eob frame_ready", 32'(fready[0]), 0);
        exp_w[0] = 24'd101;
        exp_w[1] = 24'hFFFFFD;
        for (int i = 2; i < 7; i++) exp_w[i] = 24'(i) << 16;
        exp_w[7] = 24'hFFFFFA;
        exp_cnt = 16'd1;
        recv_block(0, 7, "avg");

        // Backpressure, with the next block's first frame held at the input.
        f = '0;
        for (int i = 0; i < 8; i++) f[24*i +: 24] = 24'hC00000 | (24'(i) * 24'h111);
        for (int j = 0; j < 4; j++) send_frame(0, f);
        for (int i = 0; i < 8; i++) f[24*i +: 24] = 24'(4 * i + 8);
        fdata[0] = f;
        fvalid[0] = 1'b1;
        exp_cnt = 16'd2;
`ifdef ADS1278_FRAME_HEADER_EN
        recv_word(0, 4'hF, {8'hA5, exp_cnt}, 1'b0, "bp hdr");
`endif
        for (int i = 0; i < 8; i++) begin
            cready[0] = 1'b0;
            for (int s = 0; s < 2; s++) begin
                check("bp valid", 32'(cvalid[0]), 1);
                check("bp id", 32'(cid[0]), i);
                check("bp data", 32'(cdata[0]), 32'(24'hC00000 | (24'(i) * 24'h111)));
                check("bp last", 32'(clast[0]), 32'(i == 7));
                check("bp held_off", 32'(fready[0]), 0);
                if (s == 0) tick();
            end
            cready[0] = 1'b1;
            tick();
        end
        check("bp valid_after_last", 32'(cvalid[0]), 0);
        check("bp ready_resume", 32'(fready[0]), 1);
        tick();
        fvalid[0] = 1'b0;
        for (int j = 0; j < 3; j++) send_frame(0, '0);
        for (int i = 0; i < 8; i++) exp_w[i] = 24'(i + 2);
        exp_cnt = 16'd3;
        recv_block(0, 7, "held");

        // Clear after two frames, with a frame handshaking in the clear cycle.
        send_frame(0, {8{24'h400000}});
        send_frame(0, {8{24'h400000}});
        clr[0] = 1'b1;
        fdata[0] = {8{24'h7FFFFF}};
        fvalid[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        fvalid[0] = 1'b0;
        check("clr block_cnt", 32'(bcnt[0]), 3);
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 8; i++) f[24*i +: 24] = 24'(16 * i + j);
            send_frame(0, f);
        end
        for (int i = 0; i < 8; i++) exp_w[i] = 24'(16 * i + 1);
        exp_cnt = 16'd4;
`ifdef ADS1278_FRAME_HEADER_EN
        recv_word(0, 4'hF, {8'hA5, exp_cnt}, 1'b0, "clr hdr");
`endif
        for (int i = 0; i < 3; i++) recv_word(0, 4'(i), exp_w[i], 1'b0, "clr part");
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("midclr ch_valid", 32'(cvalid[0]), 0);
        check("midclr ch_last", 32'(clast[0]), 0);
        check("midclr block_cnt", 32'(bcnt[0]), 4);
        check("midclr frame_ready", 32'(fready[0]), 1);
        for (int i = 0; i < 8; i++) f[24*i +: 24] = 24'hFFFFFF - 24'(i);
        for (int j = 0; j < 4; j++) send_frame(0, f);
        for (int i = 0; i < 8; i++) exp_w[i] = 24'hFFFFFF - 24'(i);
        exp_cnt = 16'd5;
        recv_block(0, 7, "after_clr");

        // Channel mask: only ids 0 and 7.
        for (int i = 0; i < 8; i++) f[24*i +: 24] = 24'(10 + i);
        for (int j = 0; j < 4; j++) send_frame(1, f);
        for (int i = 0; i < 8; i++) exp_w[i] = 24'(10 + i);
        exp_cnt = 16'd1;
        recv_block(1, 7, "mask");

        // Full-scale extremes at 256 frames per block.
        for (int j = 0; j < 256; j++) send_frame(2, {8{24'h7FFFFF}});
        for (int i = 0; i < 8; i++) exp_w[i] = 24'h7FFFFF;
        exp_cnt = 16'd1;
        recv_block(2, 7, "ext_pos");
        for (int j = 0; j < 256; j++) send_frame(2, {8{24'h800000}});
        for (int i = 0; i < 8; i++) exp_w[i] = 24'h800000;
        exp_cnt = 16'd2;
        recv_block(2, 7, "ext_neg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
